// File: rtl/npc_fetch_unit.sv
// npc_fetch_unit: instruction fetch stage in front of a synchronous
// instruction store.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   imem_req/addr     read request to the store (addr is the pc register)
//   imem_rdata        instruction returned one cycle after imem_req
//   redirect_valid/pc redirect from execute; highest priority
//   out_valid/ready   head-of-queue handshake to decode
//   out_pc/out_inst   head entry (zero while out_valid is low)
//   out_misalign      only with NPC_FETCH_MISALIGN_EN: head entry came from
//                     a misaligned pc
//
// Optional feature macro: NPC_FETCH_MISALIGN_EN
//
// Queue slots are reserved when a request issues: count + pending never
// exceeds FQ_DEPTH, so a response always has a place to land.
module npc_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst
`ifdef NPC_FETCH_MISALIGN_EN
  ,
  output logic        out_misalign
`endif
);

  localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CW = $clog2(FQ_DEPTH + 1);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
`ifdef NPC_FETCH_MISALIGN_EN
    logic        mis;
`endif
  } entry_t;

  logic [63:0]   pc, pend_pc;
  logic          pending;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  entry_t        q [FQ_DEPTH];
  entry_t        head, new_ent;
  logic          deq, enq, space, issue_ok;
  logic [CW:0]   occ;

  assign out_valid = (count != '0);
  assign deq       = out_valid & out_ready;
  // A response arriving in a redirect cycle belongs to the old path.
  assign enq       = pending & ~redirect_valid;
  // Occupancy seen by a new request: queued + in flight - leaving now.
  assign occ       = {1'b0, count} + {{CW{1'b0}}, pending} - {{CW{1'b0}}, deq};
  assign space     = occ < (CW+1)'(FQ_DEPTH);
  assign imem_addr = pc;

`ifdef NPC_FETCH_MISALIGN_EN
  logic halted, pend_mis, misaligned;
  assign misaligned = (pc[1:0] != 2'b00);
  // A misaligned pc still "issues" (takes a slot) but never reaches the store.
  assign issue_ok   = rst_n & ~redirect_valid & space & ~halted;
  assign imem_req   = issue_ok & ~misaligned;
  always_comb begin
    new_ent      = '0;
    new_ent.pc   = pend_pc;
    new_ent.inst = pend_mis ? 32'h0000_0013 : imem_rdata;
    new_ent.mis  = pend_mis;
  end
  assign out_misalign = out_valid & head.mis;
`else
  assign issue_ok = rst_n & ~redirect_valid & space;
  assign imem_req = issue_ok;
  always_comb begin
    new_ent      = '0;
    new_ent.pc   = pend_pc;
    new_ent.inst = imem_rdata;
  end
`endif

  assign head     = q[rd_ptr];
  assign out_pc   = out_valid ? head.pc   : '0;
  assign out_inst = out_valid ? head.inst : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      pend_pc  <= RESET_PC;
      pending  <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
`ifdef NPC_FETCH_MISALIGN_EN
      halted   <= 1'b0;
      pend_mis <= 1'b0;
`endif
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      pending  <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
`ifdef NPC_FETCH_MISALIGN_EN
      halted   <= 1'b0;
      pend_mis <= 1'b0;
`endif
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      count   <= count + CW'(enq) - CW'(deq);
      pending <= issue_ok;
      if (issue_ok) begin
        pend_pc <= pc;
`ifdef NPC_FETCH_MISALIGN_EN
        pend_mis <= misaligned;
        if (misaligned) halted <= 1'b1;
        else            pc     <= pc + 64'd4;
`else
        pc <= pc + 64'd4;
`endif
      end
    end
  end

  // Storage needs no reset: entries are only visible when count says so.
  always_ff @(posedge clk) begin
    if (enq) q[wr_ptr] <= new_ent;
  end

endmodule

// File: doc/npc_fetch_unit.md
Name: npc_fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the synchronous instruction store.
- Holds the PC and issues one read address per cycle to the store.
- Captures the returned 32-bit instruction one cycle later and buffers it in a small FIFO.
- Hands PC/instruction pairs to decode over a valid/ready handshake; accepts redirects from execute.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset.
- FQ_DEPTH, 2, fetch queue entries (power of two, >=2); 2 gives full throughput.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  read request this cycle; combinational.
- imem_addr  output  64  read address, equals pc register.
- imem_rdata  input  32  instruction returned exactly 1 cycle after imem_req.
- redirect_valid  input  1  branch/jump redirect.
- redirect_pc  input  64  redirect target.
- out_valid  output  1  queue head valid.
- out_ready  input  1  decode accepts head.
- out_pc  output  64  PC of head entry.
- out_inst  output  32  instruction of head entry.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, pending=0, count=0, queue pointers=0.
  - out_valid=0, out_pc=0, out_inst=0.
  - imem_req=0 while rst_n=0; imem_addr=RESET_PC.
  - Reset mid-operation discards any in-flight response; the first post-reset request goes to RESET_PC.
- Registers: pc, pending (a request was issued last cycle), pend_pc, queue storage, rd/wr pointers, count (0..FQ_DEPTH).
- Handshakes:
  - deq = out_valid & out_ready.
  - enq = pending & !redirect_valid.
  - imem_req = rst_n & !redirect_valid & (count + pending - deq < FQ_DEPTH). The slot is reserved at issue, so a returning response never overflows the queue.
- Issue (imem_req=1): pend_pc<=pc; pc<=pc+4 (wraps modulo 2^64, FFFF_FFFF_FFFF_FFFC -> 0); pending<=1. Otherwise pending<=0.
- Response: when pending=1, imem_rdata is written with pend_pc at wr_ptr on the same edge (enq); count updates by enq-deq.
- Simultaneous enq and deq at count=FQ_DEPTH cannot happen, because issue was blocked.
- Simultaneous enq and deq at count=0: the entry is written, count stays 0+1-0. A deq requires out_valid, so no bypass path exists.
- Fetch-to-out latency: 2 cycles from PC load (issue edge, capture edge); out_valid rises the cycle after capture.
- Throughput: 1 instruction/cycle with FQ_DEPTH=2 and out_ready held high.
- Redirect (redirect_valid=1), with priority over everything:
  - queue flushed (count=0, pointers=0); pending response dropped; pending<=0.
  - pc<=redirect_pc; imem_req=0 that cycle.
  - out_valid reads 0 from the next cycle.
  - deq in the redirect cycle is still honoured by decode (head visible that cycle); execute is responsible for squashing it.
  - Back-to-back redirects: the last one wins; no fetch issues between them.
  - First fetch from the target is issued the cycle after the redirect; its out_valid appears 2 cycles later.
- out_valid = (count != 0); out_pc/out_inst are the head entry, held stable while out_valid & !out_ready.

Optional Feature:
- Macro: NPC_FETCH_MISALIGN_EN.
- Defined:
  - Adds output out_misalign (1 bit), queued alongside each entry.
  - When the issued pc[1:0] != 0, imem_req stays 0 and no read occurs. Next cycle an entry {pc, inst=32'h0000_0013, misalign=1} is enqueued.
  - pc then stops advancing (no further issue) until the next redirect.
- Undefined: no port; pc[1:0] are ignored, and the store sees the raw address.

Test Plan:
- Reset release, out_ready=1, store returns inst=addr[31:0]^32'hA5A5_A5A5 -> imem_addr 8000_0000, 8000_0004, ... on consecutive cycles; out_valid first high 2 cycles after release with out_pc=8000_0000, then one entry per cycle.
- out_ready=0 for 5 cycles after the first fetch -> imem_req drops once count+pending=2; out_pc stays 8000_0000; out_ready=1 resumes in order with no PC skipped or duplicated.
- redirect_valid with redirect_pc=8000_0100 while count=2, pending=1 -> next cycle out_valid=0; imem_addr=8000_0100; first output after redirect has out_pc=8000_0100.
- redirect in two consecutive cycles (8000_0200 then 8000_0300) -> no entry from 8000_0200 ever appears; the first output is 8000_0300.
- pc at FFFF_FFFF_FFFF_FFFC via redirect -> next address 0000_0000_0000_0000.
- rst_n pulsed low for one cycle mid-stream with the queue full -> out_valid=0 immediately (asynchronously); fetch restarts at 8000_0000; no stale instruction is delivered.
- (Macro on) redirect_pc=8000_0102 -> one entry with out_misalign=1, out_inst=0000_0013; no imem_req until the next redirect.
